// File: rtl/ex_mdu_stage_if.sv
// Request/response bundle between the EX-stage issue logic and the multiply/divide unit.
// master = issuing side, slave = the unit.
interface ex_mdu_stage_if #(
  parameter int XLEN = 32,
  parameter int RD_W = 5
);
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [2:0]      funct3;
  logic [XLEN-1:0] opr_a;
  logic [XLEN-1:0] opr_b;
  logic [RD_W-1:0] rd_in;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_res;
  logic [RD_W-1:0] out_rd;
  logic            busy;

  modport master (
    output flush, in_valid, funct3, opr_a, opr_b, rd_in, out_ready,
    input  in_ready, out_valid, out_res, out_rd, busy
  );

  modport slave (
    input  flush, in_valid, funct3, opr_a, opr_b, rd_in, out_ready,
    output in_ready, out_valid, out_res, out_rd, busy
  );
endinterface

// File: rtl/ex_mdu_stage.sv
// Iterative RV32M/RV64M multiply/divide unit: shift-add multiply, restoring divide, one bit per cycle.
// Optional macro MDU_FAST_MUL_EN replaces the iterative multiply with a single-cycle multiplier.
module ex_mdu_stage #(
  parameter int XLEN = 32,
  parameter int RD_W = 5
) (
  input  logic           clk,
  input  logic           rst_n,
  ex_mdu_stage_if.slave  mdu
);
  localparam int            CW   = $clog2(XLEN + 1);
  localparam logic [CW-1:0] LAST = CW'(XLEN);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_e;
  state_e state, state_n;

  logic [CW-1:0]     cnt;
  logic [2*XLEN-1:0] acc;
  logic [XLEN-1:0]   a_mag, b_mag, res;
  logic [1:0]        fn;
  logic [RD_W-1:0]   rd;
  logic              sa, sb, quick;

  // ---- accept-side decode ----
  logic            sgn_a_op, sgn_b_op, in_sa, in_sb;
  logic [XLEN-1:0] a_abs, b_abs, spc_res;
  logic            div_zero, div_ovf, div_spc;

  always_comb begin
    sgn_a_op = mdu.funct3[2] ? ~mdu.funct3[0]
                             : (mdu.funct3[1:0] == 2'b01 || mdu.funct3[1:0] == 2'b10);
    sgn_b_op = mdu.funct3[2] ? ~mdu.funct3[0] : (mdu.funct3[1:0] == 2'b01);
    in_sa    = sgn_a_op & mdu.opr_a[XLEN-1];
    in_sb    = sgn_b_op & mdu.opr_b[XLEN-1];
    a_abs    = in_sa ? -mdu.opr_a : mdu.opr_a;
    b_abs    = in_sb ? -mdu.opr_b : mdu.opr_b;
    div_zero = (mdu.opr_b == '0);
    div_ovf  = ~mdu.funct3[0] && (mdu.opr_a == {1'b1, {(XLEN-1){1'b0}}}) && (mdu.opr_b == '1);
    div_spc  = div_zero | div_ovf;
    if (div_zero) spc_res = mdu.funct3[1] ? mdu.opr_a : '1;
    else          spc_res = mdu.funct3[1] ? '0 : mdu.opr_a;
  end

`ifdef MDU_FAST_MUL_EN
  logic signed [2*XLEN+1:0] fprod;
  logic [XLEN-1:0]          fast_res;
  always_comb begin
    fprod    = $signed({in_sa, mdu.opr_a}) * $signed({in_sb, mdu.opr_b});
    fast_res = (mdu.funct3[1:0] == 2'b00) ? fprod[XLEN-1:0] : fprod[2*XLEN-1:XLEN];
  end
`else
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_p;
  logic [XLEN-1:0]   mul_res;
  // acc = {partial sum, remaining multiplier bits}; each step adds and shifts right once
  always_comb begin
    mul_sum = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, a_mag} : '0);
    mul_p   = (sa ^ sb) ? -acc : acc;
    mul_res = (fn == 2'b00) ? mul_p[XLEN-1:0] : mul_p[2*XLEN-1:XLEN];
  end
`endif

  // acc = {remainder, dividend/quotient}; shift left, trial-subtract divisor
  logic [2*XLEN:0] div_sh;
  logic [XLEN:0]   div_sub;
  logic [XLEN-1:0] quo, rem, div_res;
  always_comb begin
    div_sh  = {acc, 1'b0};
    div_sub = div_sh[2*XLEN:XLEN] - {1'b0, b_mag};
    quo     = (sa ^ sb) ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    rem     = sa ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
    div_res = fn[1] ? rem : quo;
  end

  // ---- control ----
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (mdu.in_valid) begin
`ifdef MDU_FAST_MUL_EN
        // fast multiply parks one cycle in DIV with quick set, like the divide special cases
        state_n = DIV;
`else
        state_n = mdu.funct3[2] ? DIV : MUL;
`endif
      end
      MUL:     if (cnt == LAST) state_n = DONE;
      DIV:     if (quick || cnt == LAST) state_n = DONE;
      DONE:    if (mdu.out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (mdu.flush) state_n = IDLE;
  end

  // ---- datapath ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt   <= '0;
      acc   <= '0;
      a_mag <= '0;
      b_mag <= '0;
      res   <= '0;
      fn    <= '0;
      rd    <= '0;
      sa    <= 1'b0;
      sb    <= 1'b0;
      quick <= 1'b0;
    end else if (!mdu.flush) begin
      case (state)
        IDLE: if (mdu.in_valid) begin
          fn    <= mdu.funct3[1:0];
          rd    <= mdu.rd_in;
          sa    <= in_sa;
          sb    <= in_sb;
          a_mag <= a_abs;
          b_mag <= b_abs;
          cnt   <= '0;
          acc   <= {{XLEN{1'b0}}, (mdu.funct3[2] ? a_abs : b_abs)};
`ifdef MDU_FAST_MUL_EN
          quick <= ~mdu.funct3[2] | div_spc;
          if (!mdu.funct3[2])  res <= fast_res;
          else if (div_spc)    res <= spc_res;
`else
          quick <= mdu.funct3[2] & div_spc;
          if (mdu.funct3[2] && div_spc) res <= spc_res;
`endif
        end
`ifndef MDU_FAST_MUL_EN
        MUL: begin
          if (cnt == LAST) res <= mul_res;
          else begin
            acc <= {mul_sum, acc[XLEN-1:1]};
            cnt <= cnt + CW'(1);
          end
        end
`endif
        DIV: if (!quick) begin
          if (cnt == LAST) res <= div_res;
          else begin
            if (!div_sub[XLEN]) acc <= {div_sub[XLEN-1:0], div_sh[XLEN-1:1], 1'b1};
            else                acc <= div_sh[2*XLEN-1:0];
            cnt <= cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign mdu.in_ready  = (state == IDLE);
  assign mdu.busy      = (state != IDLE);
  assign mdu.out_valid = (state == DONE);
  assign mdu.out_res   = res;
  assign mdu.out_rd    = rd;
endmodule

// File: doc/ex_mdu_stage.md
Name: ex_mdu_stage

Overview:
Parametrised multi-cycle multiply/divide execute unit implementing the RV32M/RV64M funct3 operation set, sitting beside the single-cycle ALU in the EX stage.
- Accepts one operation via a valid/ready handshake and computes iteratively, one bit per cycle.
- Holds the result and destination register until writeback accepts it.
- A pipeline flush aborts any in-flight operation.

Parameters:
XLEN, 32, operand/result width in bits (32 or 64)
RD_W, 5, destination register index width

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset, sampled on rising edge of clk
flush  in  1  synchronous abort; discards the in-flight op
in_valid  in  1  operation request
in_ready  out  1  unit can accept; high only in IDLE
funct3  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
opr_a  in  XLEN  rs1 (multiplicand/dividend)
opr_b  in  XLEN  rs2 (multiplier/divisor)
rd_in  in  RD_W  destination register
out_valid  out  1  result available
out_ready  in  1  consumer accepts result
out_res  out  XLEN  result
out_rd  out  RD_W  destination register of result
busy  out  1  state != IDLE

Behaviour:
- States: IDLE, MUL, DIV, DONE.
- Reset (rst_n=0 at an edge): state=IDLE; counter, accumulators, out_res, out_rd = 0; out_valid=0; in_ready=1 in the following cycle. Reset mid-operation discards the operation.
- Priority per edge: reset > flush > normal operation.
- Accept: in_valid && in_ready at an edge.
  - Latch funct3, rd_in, operand magnitudes and operand signs.
  - Signed ops: MULH, DIV, REM take both signs; MULHSU takes opr_a's sign only.
  - Go to MUL (funct3[2]=0) or DIV (funct3[2]=1); counter=0.
- MUL: unsigned shift-add into a 2*XLEN accumulator, one multiplier bit per edge, XLEN edges.
  - The XLEN-th edge negates the product if the latched signs differ, selects the result, and enters DONE.
  - Result selection: MUL = low XLEN bits; MULH/MULHSU/MULHU = high XLEN bits.
- DIV: restoring division on magnitudes, one quotient bit per edge, XLEN edges, then sign fix.
  - Quotient is negative iff the operand signs differ; remainder takes the dividend's sign.
  - DIV/DIVU return the quotient; REM/REMU return the remainder.
- DIV special cases, detected at accept; unit enters DONE on the next edge (latency 1):
  - divisor 0: quotient = all ones; remainder = opr_a.
  - signed overflow (opr_a = most-negative value, opr_b = -1): quotient = opr_a; remainder = 0.
- Latency: normal operations reach out_valid=1 XLEN+1 edges after the accept edge.
- DONE: out_valid=1; out_res and out_rd stay stable while out_ready=0.
  - out_valid && out_ready at an edge: go to IDLE, out_valid=0.
  - No new accept occurs in the same edge; the next op can be accepted one cycle later.
- flush: any state goes to IDLE next edge and out_valid drops.
  - flush together with in_valid in IDLE: no accept.
  - flush together with out_ready in DONE: result dropped; counts as a flush.
- in_ready = (state==IDLE); combinational from state only, never from in_valid.
- Any funct3 value is legal; no invalid encodings exist.

Optional Feature:
Macro: MDU_FAST_MUL_EN
- Defined: MUL-class ops use a single-cycle XLEN x XLEN signed-extended multiply and go IDLE -> DONE on the next edge (latency 1). The MUL state and its shift-add datapath are not synthesised. Division is unchanged.
- Undefined: iterative multiply as described, latency XLEN+1.

Test Plan:
- MUL, opr_a=7, opr_b=0xFFFFFFFD (XLEN=32) -> out_res=0xFFFFFFEB, out_valid 33 edges after accept, out_rd echoes rd_in=5.
- MULHU, both operands 0xFFFFFFFF -> 0xFFFFFFFE; MULH same operands -> 0x00000000; MULHSU opr_a=0xFFFFFFFF, opr_b=2 -> 0xFFFFFFFF.
- DIV -20/3 -> 0xFFFFFFFA; REM -20,3 -> 0xFFFFFFFE; DIVU 100/7 -> 14; REMU 100,7 -> 2.
- DIVU 1234/0 -> 0xFFFFFFFF; REM 1234,0 -> 1234; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same operands -> 0. All four complete with latency 1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_res/out_rd stable, in_ready=0; then out_ready=1 -> IDLE next edge, in_ready=1.
- Flush at cycle 10 of a DIV -> IDLE next edge, out_valid never asserts; rst_n=0 mid-MUL -> all outputs 0, in_ready=1 the following cycle.
